if_addr_xlate: RTL
==================

Name: if_addr_xlate

Overview:
- Fetch-side virtual-to-physical translation stage between the PC generator and the instruction cache.
- Accepts one fetch VA at a time and selects the translation mode: direct address (DA), direct-map window (DMW0/DMW1), or mapped lookup through the TLB fetch port.
- The TLB fetch port has 1-cycle registered latency.
- Delivers the PA to the ICache with a valid/ready handshake, or raises a fetch exception.

Parameters:
- VA_W, 32, virtual/physical address width.
- TLB_LAT, 1, cycles from presenting the VPN to a valid tlb_hit/tlb_ppn; only the value 1 is supported.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pc_vld  in  1  fetch VA valid
- pc  in  32  fetch virtual address
- pc_rdy  out  1  block accepts pc this cycle
- flush  in  1  pipeline redirect; kills the in-flight request
- crmd_da  in  1  direct-address mode
- crmd_pg  in  1  paged mode
- crmd_plv  in  2  current privilege level
- dmw0  in  32  DMW0 CSR: PLV0 enable bit0, PLV3 enable bit3, MAT[5:4], PSEG[27:25], VSEG[31:29]
- dmw1  in  32  DMW1 CSR, same layout as dmw0
- tlb_inv  in  1  TLBWR/TLBFILL/INVTLB/ASID write committed this cycle
- tlb_vpn  out  20  VA[31:12] to the TLB fetch port
- tlb_req_vld  out  1  TLB lookup strobe
- tlb_hit  in  1  TLB hit, valid TLB_LAT cycles after the strobe
- tlb_ppn  in  20  PPN, valid with tlb_hit
- ic_req_vld  out  1  ICache request valid
- ic_req_pa  out  32  physical fetch address
- ic_req_rdy  in  1  ICache accepts the request
- exc_vld  out  1  fetch exception, 1-cycle pulse
- exc_ecode  out  6  0x08 ADEF, 0x3F TLBR
- exc_badv  out  32  faulting VA

Behaviour:
- Reset:
  - State IDLE.
  - All outputs 0, except pc_rdy=1.
  - Internal VA register 0.
  - Reset is asynchronous; an asserted rst_n mid-request drops the request with no exception.
- States: IDLE, TLBW, REQ, EXCH.

- IDLE:
  - pc_rdy=1; on pc_vld & ~flush, capture pc.
  - If pc[1:0]!=0: go to EXCH with ecode 0x08.
  - Else if crmd_da: PA=pc, go to REQ.
  - Else check DMW0 then DMW1. A window hits when VSEG==pc[31:29] and the PLV bit for crmd_plv is set (bit0 for PLV0, bit3 for PLV3; PLV1/2 never hit a DMW).
    - On a hit: PA={PSEG,pc[28:0]}, go to REQ.
    - DMW0 has priority when both windows hit.
  - Else: drive tlb_req_vld=1 and tlb_vpn=pc[31:12] in the same cycle, go to TLBW.
- TLBW:
  - pc_rdy=0; sample tlb_hit and tlb_ppn.
  - On hit: PA={tlb_ppn,va[11:0]}, go to REQ.
  - On miss: go to EXCH with ecode 0x3F.
- REQ:
  - ic_req_vld=1, ic_req_pa held stable until ic_req_rdy.
  - On ic_req_rdy, return to IDLE; pc_rdy rises the following cycle (no same-cycle re-accept).
- EXCH:
  - exc_vld=1 for exactly one cycle, exc_badv=captured VA.
  - Then stall in EXCH with pc_rdy=0 until flush, then go to IDLE.
- Flush:
  - flush in any state forces IDLE next cycle and drops any pending ic_req or TLB result.
  - flush takes priority over ic_req_rdy in the same cycle: the request counts as not taken, and the ICache must ignore it.
- Ordering:
  - When crmd_da=1 and crmd_pg=1 simultaneously (illegal), DA wins.
  - CSR inputs are sampled only in IDLE at accept.
  - tlb_inv has no effect on the TLBW result already in flight.
- Throughput:
  - Mapped fetch: 3 cycles accept-to-IDLE with ic_req_rdy=1.
  - DA/DMW fetch: 2 cycles.

Optional Feature:
- Macro IF_XLATE_UTLB_EN.
- When defined: a 1-entry micro-TLB holds {valid, VPN[31:12], PPN}, filled on every TLBW hit.
  - A mapped fetch whose VPN matches a valid entry goes IDLE->REQ directly, with no tlb_req_vld.
  - The entry is invalidated by tlb_inv, flush-free transitions of crmd_da/crmd_pg, and reset.
  - tlb_inv in the same cycle as a fill leaves the entry invalid.
- When undefined: every mapped fetch takes the TLBW path; no extra state exists.

Decomposition:
- Shared package if_xlate_pkg:
  - State enum.
  - ECODE_ADEF=6'h08, ECODE_TLBR=6'h3F.
  - DMW field bit positions.
  - Function dmw_hit(dmw,va,plv).
- One natural sub-module, if_xlate_utlb, holds the micro-TLB entry; it is instantiated only under IF_XLATE_UTLB_EN.

Test Plan:
- DA: crmd_da=1, pc=0x1C000000, ic_req_rdy=1 -> ic_req_vld at cycle 1 with pa=0x1C000000; pc_rdy=1 at cycle 2.
- DMW: crmd_pg=1, plv=0, dmw0=0x90000001 (VSEG=4, PSEG=0), pc=0x8000_1234 -> pa=0x0000_1234 with no tlb_req_vld. With plv=3, the same pc -> tlb_req_vld=1.
- TLB hit: pg mode, no DMW hit, pc=0x0040_2ABC, tlb_hit=1, tlb_ppn=0x12345 next cycle -> ic_req_pa=0x12345ABC. Hold ic_req_rdy=0 for 4 cycles -> pa stable.
- TLB miss: tlb_hit=0 -> exc_vld pulse, ecode 0x3F, badv=pc; pc_rdy stays 0 until flush.
- ADEF/flush: pc=0x1C000002 -> ecode 0x08. Separately, flush while in REQ with ic_req_rdy=1 -> IDLE and no request counted.
- UTLB (macro on): two fetches in the same 4 KiB page -> the second issues no tlb_req_vld. Pulse tlb_inv, then fetch again -> tlb_req_vld reappears.

Source files
------------

// File: rtl/if_xlate_pkg.sv
// Shared types, exception codes and DMW decode helpers for the fetch address translation stage.
package if_xlate_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StTlbw,
      StReq,
      StExch
   } xlate_state_e;

   localparam logic [5:0] ECODE_ADEF = 6'h08;
   localparam logic [5:0] ECODE_TLBR = 6'h3F;

   // DMW CSR layout: PLV0 enable, PLV3 enable, MAT[5:4] (unused by fetch), PSEG, VSEG.
   localparam int unsigned DMW_PLV0_BIT = 0;
   localparam int unsigned DMW_PLV3_BIT = 3;
   localparam int unsigned DMW_PSEG_LSB = 25;
   localparam int unsigned DMW_PSEG_MSB = 27;
   localparam int unsigned DMW_VSEG_LSB = 29;
   localparam int unsigned DMW_VSEG_MSB = 31;

   // PLV1/PLV2 have no enable bit, so they never hit a window.
   function automatic logic dmw_hit(input logic [31:0] dmw, input logic [31:0] va,
                                    input logic [1:0] plv);
      logic plv_en;
      plv_en = (plv == 2'd0) ? dmw[DMW_PLV0_BIT] :
               (plv == 2'd3) ? dmw[DMW_PLV3_BIT] : 1'b0;
      return plv_en && (dmw[DMW_VSEG_MSB:DMW_VSEG_LSB] == va[31:29]);
   endfunction

   function automatic logic [31:0] dmw_pa(input logic [31:0] dmw, input logic [31:0] va);
      return {dmw[DMW_PSEG_MSB:DMW_PSEG_LSB], va[28:0]};
   endfunction

endpackage

// File: rtl/if_xlate_utlb.sv
// Single-entry micro-TLB for fetch translations; only built when IF_XLATE_UTLB_EN is defined.
module if_xlate_utlb
   import if_xlate_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [19:0] lookup_vpn,
   input  logic        fill,
   input  logic [19:0] fill_vpn,
   input  logic [19:0] fill_ppn,
   input  logic        tlb_inv,
   input  logic        crmd_da,
   input  logic        crmd_pg,
   output logic        hit,
   output logic [19:0] ppn
);

   logic        valid_q;
   logic [19:0] vpn_q;
   logic [19:0] ppn_q;
   logic [1:0]  mode_q;
   logic        mode_change;

   // Any change of DA/PG changes the meaning of a cached translation.
   assign mode_change = ({crmd_da, crmd_pg} != mode_q);

   // Entry state: invalidation beats a same-cycle fill.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         vpn_q   <= '0;
         ppn_q   <= '0;
         mode_q  <= 2'b00;
      end else begin
         mode_q <= {crmd_da, crmd_pg};
         if (tlb_inv || mode_change) begin
            valid_q <= 1'b0;
         end else if (fill) begin
            valid_q <= 1'b1;
            vpn_q   <= fill_vpn;
            ppn_q   <= fill_ppn;
         end
      end
   end

   assign hit = valid_q && (vpn_q == lookup_vpn);
   assign ppn = ppn_q;

endmodule

// File: rtl/if_addr_xlate.sv
// Fetch VA->PA translation: DA, DMW0/DMW1 windows, or mapped lookup via the TLB fetch port.
// Optional micro-TLB enabled by defining IF_XLATE_UTLB_EN.
module if_addr_xlate
   import if_xlate_pkg::*;
#(
   parameter int unsigned VA_W    = 32,
   parameter int unsigned TLB_LAT = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pc_vld,
   input  logic [VA_W-1:0] pc,
   output logic            pc_rdy,
   input  logic            flush,
   input  logic            crmd_da,
   input  logic            crmd_pg,
   input  logic [1:0]      crmd_plv,
   input  logic [31:0]     dmw0,
   input  logic [31:0]     dmw1,
   input  logic            tlb_inv,
   output logic [19:0]     tlb_vpn,
   output logic            tlb_req_vld,
   input  logic            tlb_hit,
   input  logic [19:0]     tlb_ppn,
   output logic            ic_req_vld,
   output logic [VA_W-1:0] ic_req_pa,
   input  logic            ic_req_rdy,
   output logic            exc_vld,
   output logic [5:0]      exc_ecode,
   output logic [VA_W-1:0] exc_badv
);

   if (VA_W != 32 || TLB_LAT != 1) begin : g_param_check
      $error("if_addr_xlate supports only VA_W=32 and TLB_LAT=1");
   end

   xlate_state_e    state_q;
   logic [VA_W-1:0] va_q;

   logic        accept;
   logic        adef;
   logic        dmw0_hit;
   logic        dmw1_hit;
   logic        direct;
   logic [31:0] direct_pa;
   logic        utlb_hit;
   logic [19:0] utlb_ppn;

   assign accept    = (state_q == StIdle) && pc_vld && !flush;
   assign adef      = (pc[1:0] != 2'b00);
   assign dmw0_hit  = dmw_hit(dmw0, pc, crmd_plv);
   assign dmw1_hit  = dmw_hit(dmw1, pc, crmd_plv);
   assign direct    = crmd_da || dmw0_hit || dmw1_hit;
   // DA wins over PG; DMW0 wins over DMW1.
   assign direct_pa = crmd_da  ? pc :
                      dmw0_hit ? dmw_pa(dmw0, pc) : dmw_pa(dmw1, pc);

`ifdef IF_XLATE_UTLB_EN
   logic utlb_fill;
   assign utlb_fill = (state_q == StTlbw) && tlb_hit && !flush;

   if_xlate_utlb u_utlb (
      .clk        (clk),
      .rst_n      (rst_n),
      .lookup_vpn (pc[31:12]),
      .fill       (utlb_fill),
      .fill_vpn   (va_q[31:12]),
      .fill_ppn   (tlb_ppn),
      .tlb_inv    (tlb_inv),
      .crmd_da    (crmd_da),
      .crmd_pg    (crmd_pg),
      .hit        (utlb_hit),
      .ppn        (utlb_ppn)
   );
`else
   logic unused_inputs;
   assign unused_inputs = ^{crmd_pg, tlb_inv};
   assign utlb_hit      = 1'b0;
   assign utlb_ppn      = '0;
`endif

   // The TLB strobe must leave in the accept cycle to meet the 1-cycle lookup latency.
   assign tlb_req_vld = accept && !adef && !direct && !utlb_hit;
   assign tlb_vpn     = tlb_req_vld ? pc[31:12] : '0;

   // Translation FSM with registered handshake and exception outputs; flush overrides all.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         va_q       <= '0;
         pc_rdy     <= 1'b1;
         ic_req_vld <= 1'b0;
         ic_req_pa  <= '0;
         exc_vld    <= 1'b0;
         exc_ecode  <= '0;
         exc_badv   <= '0;
      end else begin
         exc_vld <= 1'b0;
         if (flush) begin
            state_q    <= StIdle;
            pc_rdy     <= 1'b1;
            ic_req_vld <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (pc_vld) begin
                     va_q   <= pc;
                     pc_rdy <= 1'b0;
                     if (adef) begin
                        state_q   <= StExch;
                        exc_vld   <= 1'b1;
                        exc_ecode <= ECODE_ADEF;
                        exc_badv  <= pc;
                     end else if (direct) begin
                        state_q    <= StReq;
                        ic_req_vld <= 1'b1;
                        ic_req_pa  <= direct_pa;
                     end else if (utlb_hit) begin
                        state_q    <= StReq;
                        ic_req_vld <= 1'b1;
                        ic_req_pa  <= {utlb_ppn, pc[11:0]};
                     end else begin
                        state_q <= StTlbw;
                     end
                  end
               end
               StTlbw: begin
                  if (tlb_hit) begin
                     state_q    <= StReq;
                     ic_req_vld <= 1'b1;
                     ic_req_pa  <= {tlb_ppn, va_q[11:0]};
                  end else begin
                     state_q   <= StExch;
                     exc_vld   <= 1'b1;
                     exc_ecode <= ECODE_TLBR;
                     exc_badv  <= va_q;
                  end
               end
               StReq: begin
                  if (ic_req_rdy) begin
                     state_q    <= StIdle;
                     ic_req_vld <= 1'b0;
                     pc_rdy     <= 1'b1;
                  end
               end
               StExch: begin
                  // Hold until the pipeline redirects with flush.
                  state_q <= StExch;
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule
